// File: rtl/vector_checker_pkg.sv
// Shared types and field-layout helpers for the vector checker.
// A stored vector is packed as {stim, expected, mask}, mask in the LSBs.
package vector_checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    APPLY = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned MASK_LSB = 0;

  // Total width of one stored vector
  function automatic int unsigned vec_w(input int unsigned stim_w, input int unsigned resp_w);
    return stim_w + 2 * resp_w;
  endfunction

  // LSB of the expected-response field
  function automatic int unsigned exp_lsb(input int unsigned resp_w);
    return resp_w;
  endfunction

  // LSB of the stimulus field
  function automatic int unsigned stim_lsb(input int unsigned resp_w);
    return 2 * resp_w;
  endfunction

endpackage

// File: rtl/vector_mem.sv
// Vector storage: DEPTH x WIDTH RAM, one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
// Ports: clk; we/waddr/wdata write port; re/raddr read request, rdata valid
// the cycle after re.
module vector_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-during-write to the same address returns the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vector_checker.sv
// Test-vector player/checker. Replays stored {stim, expected, mask} vectors
// into a DUT, waits LAT cycles, compares the masked response and reports
// error count, pass flag and the first failing vector.
// Ports: clk/reset (sync, active-high); load_we/load_addr/load_data write the
// vector memory while idle; num_vec/start launch a run; stim drives the DUT
// and dut_resp returns its answer; busy/done/pass/err_count/first_err_*
// report status.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int unsigned STIM_W      = 7,
  parameter int unsigned RESP_W      = 4,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned LAT         = 0,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [STIM_W+2*RESP_W-1:0] load_data,
  input  logic [$clog2(DEPTH):0]     num_vec,
  input  logic                       start,
  output logic [STIM_W-1:0]          stim,
  input  logic [RESP_W-1:0]          dut_resp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_W-1:0]           err_count,
  output logic                       first_err_valid,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic [RESP_W-1:0]          first_err_got
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned NW       = AW + 1;
  localparam int unsigned VW       = vec_w(STIM_W, RESP_W);
  localparam int unsigned EXP_LSB  = exp_lsb(RESP_W);
  localparam int unsigned STIM_LSB = stim_lsb(RESP_W);
  localparam int unsigned WW       = (LAT > 0) ? $clog2(LAT + 1) : 1;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q;
  logic [NW-1:0]     nv_q;
  logic [WW-1:0]     wait_q;
  logic [RESP_W-1:0] exp_q;
  logic [RESP_W-1:0] mask_q;
  logic [VW-1:0]     rdata;

  logic              run_start_c;
  logic              mem_re_c;
  logic              load_vec_c;
  logic              check_c;
  logic              mismatch_c;
  logic              last_c;
  logic              wait_done_c;
  logic              err_hit_c;
  logic              mem_we_c;
  logic [CNT_W-1:0]  err_next_c;

  // Memory is frozen for the duration of a run
  assign mem_we_c = load_we & ~busy;

  vector_mem #(
    .DEPTH (DEPTH),
    .WIDTH (VW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re_c),
    .raddr (idx_q),
    .rdata (rdata)
  );

  assign mismatch_c  = |((dut_resp ^ exp_q) & mask_q);
  assign last_c      = ({1'b0, idx_q} == NW'(nv_q - NW'(1)));
  assign wait_done_c = (wait_q == WW'(LAT));
  assign err_hit_c   = check_c & mismatch_c;

  // Saturating error count, cleared when a run is launched
  always_comb begin
    err_next_c = err_count;
    if (run_start_c) begin
      err_next_c = '0;
    end else if (err_hit_c && !(&err_count)) begin
      err_next_c = err_count + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (num_vec == '0) ? DONE : FETCH;
      end
      FETCH: state_d = APPLY;
      APPLY: begin
        if (wait_done_c) state_d = CHECK;
      end
      CHECK: begin
        if (last_c || ((STOP_ON_ERR != 0) && mismatch_c)) state_d = DONE;
        else                                              state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    run_start_c = 1'b0;
    mem_re_c    = 1'b0;
    load_vec_c  = 1'b0;
    check_c     = 1'b0;
    case (state_q)
      IDLE, DONE: run_start_c = start;
      FETCH:      mem_re_c    = 1'b1;
      APPLY:      load_vec_c  = (wait_q == '0);
      CHECK:      check_c     = 1'b1;
      default:    ;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q           <= '0;
      nv_q            <= '0;
      wait_q          <= '0;
      exp_q           <= '0;
      mask_q          <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
    end else begin
      busy      <= (state_d == FETCH) || (state_d == APPLY) || (state_d == CHECK);
      done      <= (state_d == DONE);
      pass      <= (state_d == DONE) && (err_next_c == '0);
      err_count <= err_next_c;

      if (run_start_c) begin
        nv_q            <= (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
        idx_q           <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        first_err_got   <= '0;
      end

      // Wait counter restarts on each fetch, then covers the LAT settle cycles
      if (state_q == FETCH) begin
        wait_q <= '0;
      end else if ((state_q == APPLY) && !wait_done_c) begin
        wait_q <= wait_q + WW'(1);
      end

      if (load_vec_c) begin
        stim   <= rdata[STIM_LSB +: STIM_W];
        exp_q  <= rdata[EXP_LSB +: RESP_W];
        mask_q <= rdata[MASK_LSB +: RESP_W];
      end

      if (err_hit_c && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= idx_q;
        first_err_got   <= dut_resp;
      end

      if (check_c && (state_d == FETCH)) idx_q <= idx_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Self-checking bench for vector_checker: four instances with different
// parameter sets, each looped back through an ALU-control reference model.
module tb_vector_checker;

  localparam int unsigned SW = 7;
  localparam int unsigned RW = 4;
  localparam int unsigned VW = SW + 2 * RW;
  localparam int unsigned NI = 4;
  localparam int          BUDGET = 300;

  typedef struct {
    logic [SW-1:0] s;
    logic [RW-1:0] e;
    logic [RW-1:0] m;
  } vec_t;

  typedef struct {
    int inst;  // 0 default, 1 stop-on-err, 2 narrow counter, 3 latency 2
    int nv;
    int md;    // 0 model, 1 forced zero, 2 vector 2 corrupted
    int cyc;
    int err;
    int ps;
    int fev;
    int fidx;
    int fgot;
    int st;
  } run_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NI-1:0] load_we;
  logic [7:0]    load_addr;
  logic [VW-1:0] load_data;
  logic [8:0]    num_vec;
  logic [NI-1:0] start;
  logic [1:0]    mode [NI];

  logic [SW-1:0] stim_a, stim_s, stim_c, stim_l;
  logic [RW-1:0] resp_a, resp_s, resp_c, resp_l;
  logic          busy_a, busy_s, busy_c, busy_l;
  logic          done_a, done_s, done_c, done_l;
  logic          pass_a, pass_s, pass_c, pass_l;
  logic [7:0]    err_a, err_s, err_l;
  logic [1:0]    err_c;
  logic          fev_a, fev_s, fev_c, fev_l;
  logic [7:0]    fidx_a;
  logic [3:0]    fidx_s, fidx_l;
  logic [2:0]    fidx_c;
  logic [RW-1:0] fgot_a, fgot_s, fgot_c, fgot_l;
  logic [RW-1:0] pipe1, pipe2;

  logic [SW-1:0] stim_w [NI];
  logic [7:0]    err_w  [NI];
  logic [7:0]    fidx_w [NI];
  logic [RW-1:0] fgot_w [NI];
  logic [NI-1:0] busy_w, done_w, pass_w, fev_w;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [8];
  run_t runs [13];
  run_t sb [$];

  // Reference ALU control: ALUOp 00 add, 01 sub, 10 decode func, 11 invalid
  function automatic logic [RW-1:0] alu_ctrl(input logic [SW-1:0] s);
    logic [1:0] op;
    logic [4:0] fn;
    op = s[6:5];
    fn = s[4:0];
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b10: begin
        case (fn)
          5'b00000: return 4'b0010;
          5'b10000: return 4'b0110;
          5'b00100: return 4'b0000;
          5'b00101: return 4'b0001;
          default:  return 4'b1111;
        endcase
      end
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [RW-1:0] respond(input logic [SW-1:0] s, input logic [1:0] m);
    case (m)
      2'd1:    return '0;
      2'd2:    return alu_ctrl(s) ^ ((s == 7'h40) ? 4'b0100 : 4'b0000);
      default: return alu_ctrl(s);
    endcase
  endfunction

  assign resp_a = respond(stim_a, mode[0]);
  assign resp_s = respond(stim_s, mode[1]);
  assign resp_c = respond(stim_c, mode[2]);
  assign resp_l = pipe2;

  // Two-stage registered DUT for the LAT=2 instance
  always_ff @(posedge clk) begin
    pipe1 <= respond(stim_l, mode[3]);
    pipe2 <= pipe1;
  end

  always_comb begin
    stim_w[0] = stim_a;  stim_w[1] = stim_s;  stim_w[2] = stim_c;  stim_w[3] = stim_l;
    err_w[0]  = err_a;   err_w[1]  = err_s;   err_w[2]  = 8'(err_c); err_w[3] = err_l;
    fidx_w[0] = fidx_a;  fidx_w[1] = 8'(fidx_s); fidx_w[2] = 8'(fidx_c); fidx_w[3] = 8'(fidx_l);
    fgot_w[0] = fgot_a;  fgot_w[1] = fgot_s;  fgot_w[2] = fgot_c;  fgot_w[3] = fgot_l;
    busy_w = {busy_l, busy_c, busy_s, busy_a};
    done_w = {done_l, done_c, done_s, done_a};
    pass_w = {pass_l, pass_c, pass_s, pass_a};
    fev_w  = {fev_l, fev_c, fev_s, fev_a};
  end

  vector_checker u_a (
    .clk(clk), .reset(reset), .load_we(load_we[0]), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start[0]), .stim(stim_a),
    .dut_resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_idx(fidx_a),
    .first_err_got(fgot_a)
  );

  vector_checker #(.DEPTH(16), .STOP_ON_ERR(1)) u_s (
    .clk(clk), .reset(reset), .load_we(load_we[1]), .load_addr(load_addr[3:0]),
    .load_data(load_data), .num_vec(num_vec[4:0]), .start(start[1]), .stim(stim_s),
    .dut_resp(resp_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_valid(fev_s), .first_err_idx(fidx_s),
    .first_err_got(fgot_s)
  );

  vector_checker #(.DEPTH(8), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .load_we(load_we[2]), .load_addr(load_addr[2:0]),
    .load_data(load_data), .num_vec(num_vec[3:0]), .start(start[2]), .stim(stim_c),
    .dut_resp(resp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_err_valid(fev_c), .first_err_idx(fidx_c),
    .first_err_got(fgot_c)
  );

  vector_checker #(.DEPTH(16), .LAT(2)) u_l (
    .clk(clk), .reset(reset), .load_we(load_we[3]), .load_addr(load_addr[3:0]),
    .load_data(load_data), .num_vec(num_vec[4:0]), .start(start[3]), .stim(stim_l),
    .dut_resp(resp_l), .busy(busy_l), .done(done_l), .pass(pass_l),
    .err_count(err_l), .first_err_valid(fev_l), .first_err_idx(fidx_l),
    .first_err_got(fgot_l)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic run_t mk(input int inst, input int nv, input int md, input int cyc,
                              input int err, input int ps, input int fev, input int fidx,
                              input int fgot, input int st);
    run_t r;
    r.inst = inst; r.nv = nv; r.md = md; r.cyc = cyc; r.err = err;
    r.ps = ps; r.fev = fev; r.fidx = fidx; r.fgot = fgot; r.st = st;
    return r;
  endfunction

  // act: 0 plain, 1 write while busy, 2 start while busy, 4 write together with start
  task automatic do_run(input string tag, input run_t r, input int act);
    run_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    num_vec         = 9'(r.nv);
    mode[r.inst]    = 2'(r.md);
    start[r.inst]   = 1'b1;
    if (act == 4) begin
      load_we[r.inst] = 1'b1;
      load_addr       = 8'd5;
      load_data       = {7'h60, 4'h0, 4'hF};
    end
    sb.push_back(r);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      start   = '0;
      load_we = '0;
      if (act == 1 && n == 3) begin
        load_we[r.inst] = 1'b1;
        load_addr       = 8'd1;
        load_data       = {7'h20, 4'hF, 4'hF};
      end
      if (act == 2 && n == 5) begin
        num_vec       = '0;
        start[r.inst] = 1'b1;
      end
      seen = done_w[r.inst];
    end
    e = sb.pop_front();
    chk({tag, ".cycles"}, seen ? n : -1, e.cyc);
    chk({tag, ".busy"}, int'(busy_w[e.inst]), 0);
    chk({tag, ".pass"}, int'(pass_w[e.inst]), e.ps);
    chk({tag, ".err_count"}, int'(err_w[e.inst]), e.err);
    chk({tag, ".first_err_valid"}, int'(fev_w[e.inst]), e.fev);
    chk({tag, ".first_err_idx"}, int'(fidx_w[e.inst]), e.fidx);
    chk({tag, ".first_err_got"}, int'(fgot_w[e.inst]), e.fgot);
    chk({tag, ".stim"}, int'(stim_w[e.inst]), e.st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'h00, 4'b0010, 4'hF};
    vecs[1] = '{7'h20, 4'b0110, 4'hF};
    vecs[2] = '{7'h40, 4'b0010, 4'hF};
    vecs[3] = '{7'h50, 4'b0110, 4'hF};
    vecs[4] = '{7'h45, 4'b0001, 4'hF};
    vecs[5] = '{7'h60, 4'b1111, 4'hF};
    vecs[6] = '{7'h44, 4'b0000, 4'hF};
    vecs[7] = '{7'h4A, 4'b0000, 4'h0};

    //            inst nv md cyc err ps fev fidx fgot stim
    runs[0]  = mk(0,  4, 0, 13, 0, 1, 0, 0, 0,  'h50);
    runs[1]  = mk(0,  4, 1, 13, 4, 0, 1, 0, 0,  'h50);
    runs[2]  = mk(0,  8, 0, 25, 0, 1, 0, 0, 0,  'h4A);
    runs[3]  = mk(0,  0, 1,  1, 0, 1, 0, 0, 0,  'h4A);
    runs[4]  = mk(0,  8, 1, 25, 6, 0, 1, 0, 0,  'h4A);
    runs[5]  = mk(0,  4, 2, 13, 1, 0, 1, 2, 6,  'h50);
    runs[6]  = mk(1,  4, 2, 10, 1, 0, 1, 2, 6,  'h40);
    runs[7]  = mk(1,  4, 0, 13, 0, 1, 0, 0, 0,  'h50);
    runs[8]  = mk(2,  8, 1, 25, 3, 0, 1, 0, 0,  'h4A);
    runs[9]  = mk(2, 15, 0, 25, 0, 1, 0, 0, 0,  'h4A);
    runs[10] = mk(3,  4, 0, 21, 0, 1, 0, 0, 0,  'h50);
    runs[11] = mk(3,  4, 1, 21, 4, 0, 1, 0, 0,  'h50);
    runs[12] = mk(1,  5, 1,  4, 1, 0, 1, 0, 0,  'h00);

    reset     = 1'b1;
    load_we   = '0;
    load_addr = '0;
    load_data = '0;
    num_vec   = '0;
    start     = '0;
    for (int i = 0; i < int'(NI); i++) mode[i] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < int'(NI); i++) begin
      chk($sformatf("reset[%0d].busy", i), int'(busy_w[i]), 0);
      chk($sformatf("reset[%0d].done", i), int'(done_w[i]), 0);
      chk($sformatf("reset[%0d].pass", i), int'(pass_w[i]), 0);
      chk($sformatf("reset[%0d].err_count", i), int'(err_w[i]), 0);
      chk($sformatf("reset[%0d].first_err_valid", i), int'(fev_w[i]), 0);
      chk($sformatf("reset[%0d].stim", i), int'(stim_w[i]), 0);
    end

    // Same eight vectors into every instance
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_we   = '1;
      load_addr = 8'(i);
      load_data = {vecs[i].s, vecs[i].e, vecs[i].m};
    end
    @(negedge clk);
    load_we = '0;

    for (int i = 0; i < 13; i++) do_run($sformatf("run%0d", i), runs[i], 0);

    // Write while busy is dropped: this run and the re-run are both clean
    do_run("busy_write", runs[0], 1);
    do_run("busy_write_rerun", runs[0], 0);
    // Start while busy is ignored
    do_run("busy_start", runs[0], 2);

    // Reset in the middle of vector 2 on the LAT=2 instance
    @(negedge clk);
    num_vec  = 9'd4;
    mode[3]  = 2'd1;
    start[3] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      start = '0;
    end
    chk("midrun.err_count", int'(err_l), 2);
    chk("midrun.busy", int'(busy_l), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset.busy", int'(busy_l), 0);
    chk("midreset.done", int'(done_l), 0);
    chk("midreset.err_count", int'(err_l), 0);
    chk("midreset.first_err_valid", int'(fev_l), 0);
    chk("midreset.stim", int'(stim_l), 0);
    do_run("after_reset", runs[10], 0);

    // Write and start in the same idle cycle: write to index 5 lands
    do_run("write_with_start", mk(0, 8, 0, 25, 1, 0, 1, 5, 15, 'h4A), 4);
    do_run("write_with_start_rerun", mk(0, 8, 0, 25, 1, 0, 1, 5, 15, 'h4A), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
